// File: rtl/tdm_demux2.sv
// Two-channel bit-interleaved TDM receiver: rebuilds one W-bit word per
// channel from a sync-framed serial stream and holds one frame for a valid/ready consumer.
module tdm_demux2 #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic         in_sync,
    input  logic         in_bit,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_a,
    output logic [W-1:0] out_b,
    output logic         overrun,
    output logic         sync_err,
    input  logic         clr_err
);

    localparam int CW = ($clog2(2 * W) > 0) ? $clog2(2 * W) : 1;
    localparam logic [CW-1:0] LAST = CW'(2 * W - 1);

    typedef enum logic {
        HUNT,
        SHIFT
    } state_t;

    state_t        r_state;
    logic [CW-1:0] r_slot;
    logic [W-1:0]  r_a;
    logic [W-1:0]  r_b;
    logic [W-1:0]  r_out_a;
    logic [W-1:0]  r_out_b;
    logic          r_valid;
    logic          r_overrun;
    logic          r_sync_err;

    logic [CW-1:0] w_slot;
    logic          w_cap;
    logic          w_done;
    logic          w_resync;
    logic          w_load;
    logic          w_drop;
    logic [W-1:0]  w_a_next;
    logic [W-1:0]  w_b_next;

    // A sync beat always lands in slot 0, whatever the current slot is.
    assign w_slot   = in_sync ? '0 : r_slot;
    assign w_cap    = in_valid && (in_sync || r_state == SHIFT);
    assign w_done   = in_valid && !in_sync && r_state == SHIFT && r_slot == LAST;
    assign w_resync = in_valid && in_sync && r_state == SHIFT;
    assign w_load   = w_done && (!r_valid || out_ready);
    assign w_drop   = w_done && r_valid && !out_ready;

    always_comb begin
        w_a_next = r_a;
        w_b_next = r_b;
        if (w_cap) begin
            for (int k = 0; k < W; k++) begin
                if (w_slot == CW'(2 * k))
                    w_a_next[W-1-k] = in_bit;
                if (w_slot == CW'(2 * k + 1))
                    w_b_next[W-1-k] = in_bit;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= HUNT;
            r_slot     <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_out_a    <= '0;
            r_out_b    <= '0;
            r_valid    <= 1'b0;
            r_overrun  <= 1'b0;
            r_sync_err <= 1'b0;
        end else begin
            if (w_cap) begin
                r_a <= w_a_next;
                r_b <= w_b_next;
            end

            if (in_valid) begin
                if (in_sync) begin
                    r_state <= SHIFT;
                    r_slot  <= CW'(1);
                end else if (r_state == SHIFT) begin
                    if (r_slot == LAST) begin
                        r_state <= HUNT;
                        r_slot  <= '0;
                    end else begin
                        r_slot <= r_slot + CW'(1);
                    end
                end
            end

            // Completed words come from the next-value bus so the last bit is included.
            if (w_load) begin
                r_valid <= 1'b1;
                r_out_a <= w_a_next;
                r_out_b <= w_b_next;
            end else if (r_valid && out_ready) begin
                r_valid <= 1'b0;
            end

            if (w_drop)
                r_overrun <= 1'b1;
            else if (clr_err)
                r_overrun <= 1'b0;

            if (w_resync)
                r_sync_err <= 1'b1;
            else if (clr_err)
                r_sync_err <= 1'b0;
        end
    end

    assign out_valid = r_valid;
    assign out_a     = r_out_a;
    assign out_b     = r_out_b;
    assign overrun   = r_overrun;
    assign sync_err  = r_sync_err;

endmodule

// File: tb/tb_tdm_demux2.sv
// Bench for tdm_demux2: directed frames plus random traffic, checked
// by a frame-level reference model feeding a scoreboard queue.
module tb_tdm_demux2;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_sync = 1'b0;
    logic         in_bit = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_a;
    logic [W-1:0] out_b;
    logic         overrun;
    logic         sync_err;
    logic         clr_err = 1'b0;

    int n_checks = 0;
    int n_pass = 0;

    // Reference model state: bits of the frame in progress, held frame, flags.
    logic           bits[$];
    logic [2*W-1:0] exp_q[$];
    logic           m_valid = 1'b0;
    logic           m_ovr = 1'b0;
    logic           m_serr = 1'b0;

    tdm_demux2 #(.W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_sync   (in_sync),
        .in_bit    (in_bit),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_a     (out_a),
        .out_b     (out_b),
        .overrun   (overrun),
        .sync_err  (sync_err),
        .clr_err   (clr_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
    endtask

    task automatic model_reset();
        bits.delete();
        exp_q.delete();
        m_valid = 1'b0;
        m_ovr   = 1'b0;
        m_serr  = 1'b0;
    endtask

    always @(posedge clk) begin
        logic           done;
        logic           ovr_set;
        logic           serr_set;
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        done     = 1'b0;
        ovr_set  = 1'b0;
        serr_set = 1'b0;
        a        = '0;
        b        = '0;
        if (!rst_n) begin
            model_reset();
        end else begin
            if (in_valid) begin
                if (in_sync) begin
                    if (bits.size() != 0)
                        serr_set = 1'b1;
                    bits.delete();
                    bits.push_back(in_bit);
                end else if (bits.size() != 0) begin
                    bits.push_back(in_bit);
                    if (bits.size() == 2 * W) begin
                        for (int k = 0; k < W; k++) begin
                            a[W-1-k] = bits[2*k];
                            b[W-1-k] = bits[2*k+1];
                        end
                        done = 1'b1;
                        bits.delete();
                    end
                end
            end
            if (done && (!m_valid || out_ready)) begin
                m_valid = 1'b1;
                exp_q.push_back({a, b});
            end else begin
                if (done)
                    ovr_set = 1'b1;
                else if (m_valid && out_ready)
                    m_valid = 1'b0;
            end
            if (ovr_set)
                m_ovr = 1'b1;
            else if (clr_err)
                m_ovr = 1'b0;
            if (serr_set)
                m_serr = 1'b1;
            else if (clr_err)
                m_serr = 1'b0;
        end
    end

    always @(posedge clk) begin
        #2;
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        chk("overrun", 32'(overrun), 32'(m_ovr));
        chk("sync_err", 32'(sync_err), 32'(m_serr));
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL pop: DUT presented %0h with no frame expected",
                         {out_a, out_b});
            end else begin
                chk("frame", 32'({out_a, out_b}), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic beat(input logic s, input logic b);
        in_valid = 1'b1;
        in_sync  = s;
        in_bit   = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sync  = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [2*W-1:0] ser(input logic [W-1:0] a,
                                           input logic [W-1:0] b);
        logic [2*W-1:0] s;
        for (int k = 0; k < W; k++) begin
            s[2*k]   = a[W-1-k];
            s[2*k+1] = b[W-1-k];
        end
        return s;
    endfunction

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                        input int nbeats, input int gap_after, input int gap);
        logic [2*W-1:0] s;
        s = ser(a, b);
        for (int i = 0; i < nbeats; i++) begin
            beat(i == 0, s[i]);
            if (i == gap_after)
                idle(gap);
        end
    endtask

    initial begin
        #3;
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_words", 32'({out_a, out_b}), 0);
        chk("rst_flags", 32'({overrun, sync_err}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic frame: a=1010, b=0110, out_ready=1.
        out_ready = 1'b1;
        send(4'b1010, 4'b0110, 2*W, -1, 0);
        chk("basic_valid", 32'(out_valid), 1);
        chk("basic_a", 32'(out_a), 32'(4'b1010));
        chk("basic_b", 32'(out_b), 32'(4'b0110));
        idle(1);
        chk("basic_pulse", 32'(out_valid), 0);

        // Gapped input.
        send(4'b1010, 4'b0110, 2*W, 3, 3);
        chk("gap_valid", 32'(out_valid), 1);
        chk("gap_words", 32'({out_a, out_b}), 32'(8'b1010_0110));
        idle(2);

        // Back-pressure and overrun.
        out_ready = 1'b0;
        send(4'b1010, 4'b0110, 2*W, -1, 0);
        send(4'b1111, 4'b0000, 2*W, -1, 0);
        idle(2);
        chk("bp_words", 32'({out_a, out_b}), 32'(8'b1010_0110));
        chk("bp_overrun", 32'(overrun), 1);
        out_ready = 1'b1;
        idle(1);
        out_ready = 1'b0;
        chk("bp_drained", 32'(out_valid), 0);
        clr_err = 1'b1;
        idle(1);
        clr_err = 1'b0;
        chk("bp_clr", 32'(overrun), 0);

        // Simultaneous consume and load.
        send(4'b1010, 4'b0110, 2*W, -1, 0);
        send(4'b1111, 4'b0000, 2*W - 1, -1, 0);
        begin
            logic [2*W-1:0] s;
            s = ser(4'b1111, 4'b0000);
            out_ready = 1'b1;
            beat(1'b0, s[2*W-1]);
        end
        chk("sim_valid", 32'(out_valid), 1);
        chk("sim_words", 32'({out_a, out_b}), 32'(8'b1111_0000));
        chk("sim_overrun", 32'(overrun), 0);
        idle(2);

        // Mid-frame resync.
        beat(1'b1, 1'b1);
        beat(1'b0, 1'b1);
        send(4'b0011, 4'b1100, 2*W, -1, 0);
        chk("rs_serr", 32'(sync_err), 1);
        chk("rs_words", 32'({out_a, out_b}), 32'(8'b0011_1100));
        clr_err = 1'b1;
        idle(1);
        clr_err = 1'b0;

        // Reset with a held frame and a partial frame at slot 5.
        out_ready = 1'b0;
        send(4'b1010, 4'b0110, 2*W, -1, 0);
        send(4'b0101, 4'b1001, 5, -1, 0);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("arst_valid", 32'(out_valid), 0);
        chk("arst_words", 32'({out_a, out_b}), 0);
        chk("arst_flags", 32'({overrun, sync_err}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        for (int i = 0; i < 2 * W + 2; i++)
            beat(1'b0, 1'(i));
        idle(1);
        chk("hunt_ignore", 32'(out_valid), 0);
        send(4'b1100, 4'b0011, 2*W, -1, 0);
        chk("hunt_words", 32'({out_a, out_b}), 32'(8'b1100_0011));

        // Random traffic.
        for (int c = 0; c < 4000; c++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            if (bits.size() == 0)
                in_sync = ($urandom_range(0, 3) != 0);
            else
                in_sync = ($urandom_range(0, 15) == 0);
            in_bit    = 1'($urandom);
            out_ready = 1'($urandom);
            clr_err   = ($urandom_range(0, 19) == 0);
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        in_sync   = 1'b0;
        clr_err   = 1'b0;
        out_ready = 1'b1;
        idle(4);
        chk("drained", 32'(exp_q.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
